convol_result_scaler_fifo: RTL and testbench
============================================

// Module: convol_result_scaler_fifo
// PURPOSE
//  Stage directly downstream of the convolver result port (output_data / output_data_valid).
//  Rescales each FULL_SIZE result to DATA_SIZE: round-half-up, arithmetic right shift, saturate.
//  Buffers results in a DEPTH-entry first-word-fall-through FIFO with a valid/ready output,
//  because the convolver has no backpressure. Reports overflow drops and saturation events.
// PARAMETERS
//  DATA_SIZE    16   output sample width, signed
//  WINDOW_SIZE  8    convolver taps; used only for the FULL_SIZE default
//  FULL_SIZE    2*DATA_SIZE+$clog2(WINDOW_SIZE) (=35)   input result width, signed
//  SHIFT        15   right-shift amount, 0..FULL_SIZE-1; SHIFT=0 disables rounding
//  DEPTH        16   FIFO entries, power of two, >=2
// PORTS
//  clk                input   1              single clock, rising edge
//  reset              input   1              synchronous, active-high
//  output_data        input   FULL_SIZE      signed convolver result
//  output_data_valid  input   1              result qualifier, one sample per cycle max
//  out_data           output  DATA_SIZE      signed scaled sample at FIFO head
//  out_valid          output  1              head valid
//  out_ready          input   1              consumer accepts head when out_valid&&out_ready
//  fill_level         output  $clog2(DEPTH)+1   current FIFO occupancy
//  overflow           output  1              sticky: a sample was dropped
//  sat_count          output  16             saturated samples, stops at 16'hFFFF
//  clear_flags        input   1              clears overflow and sat_count
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, fill_level=0, overflow=0, sat_count=0.
//   Stage register, pointers and memory-valid state are cleared; memory contents need not be.
//  Stage 1 (scale), registered:
//   - Rounded value r = output_data + (SHIFT>0 ? 1<<(SHIFT-1) : 0), in FULL_SIZE+1 bits (no wrap).
//   - s = r >>> SHIFT (arithmetic).
//   - Clip s to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
//   - A clip raises sat_pulse in the same cycle as s_valid.
//   - s_valid = output_data_valid delayed one cycle.
//  Stage 2 (FIFO):
//   - Write when s_valid.
//   - Pop when out_valid && out_ready.
//   - Full and push without pop: sample dropped, overflow <= 1.
//   - Full and push with pop: both happen, fill_level unchanged.
//   - Empty and push: the word appears at out_data with out_valid=1 on the next cycle.
//     Latency output_data_valid -> out_valid is 2 cycles.
//   - Empty and pop: impossible, because out_valid=0.
//   - Pointers wrap modulo DEPTH. fill_level = pushes - pops, always in range 0..DEPTH.
//   - out_data holds its value while out_valid && !out_ready.
//  Counters:
//   - sat_count increments on every sat_pulse, including for samples later dropped.
//   - sat_count saturates at 16'hFFFF.
//   - clear_flags has priority over a same-cycle set or increment:
//     result is overflow=0, sat_count=0.
//  Reset mid-operation: the FIFO empties, the in-flight stage-1 sample is discarded,
//   and out_valid=0 on the next cycle.
//  No combinational path from output_data_valid to out_valid.
//  out_valid depends only on state, not on out_ready.
// TESTING (SHIFT=4, DATA_SIZE=16, DEPTH=4 unless noted)
//  1. Rounding:
//     - Inputs 64, 24, -24, 7, sent back-to-back, out_ready=1.
//     - Outputs 4, 2, -1, 0, each 2 cycles after its input.
//     - sat_count=0.
//  2. Saturation:
//     - Inputs 2^30 and -2^30.
//     - Outputs 32767 and -32768. sat_count=2.
//     - clear_flags pulse -> sat_count=0.
//  3. Backpressure and overflow:
//     - out_ready=0, 6 inputs with values 16..96 step 16.
//     - fill_level=4 and overflow=1.
//     - Then out_ready=1: outputs 1, 2, 3, 4 only, and fill_level returns to 0.
//  4. Full with simultaneous push and pop:
//     - FIFO held at 4 entries, out_ready=1, inputs streamed continuously.
//     - No drops, overflow stays 0, fill_level stays 4, outputs keep input order.
//  5. Reset mid-stream:
//     - Assert reset with 3 entries stored and 1 sample in flight.
//     - Next cycle: out_valid=0, fill_level=0.
//     - The first post-reset input of 32 yields a single output of 2.
//  6. SHIFT=0 build: input 1234 -> 1234; input 40000 -> 32767 with sat_count=1.

Source files
------------

// File: rtl/convol_result_scaler_fifo.sv
// Rescales signed convolver results (round-half-up, arithmetic shift, saturate) and
// buffers them in a first-word-fall-through FIFO with a valid/ready output.
module convol_result_scaler_fifo #(
    parameter int DATA_SIZE   = 16,
    parameter int WINDOW_SIZE = 8,
    parameter int FULL_SIZE   = 2 * DATA_SIZE + $clog2(WINDOW_SIZE),
    parameter int SHIFT       = 15,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [FULL_SIZE-1:0]     output_data,
    input  logic                     output_data_valid,
    output logic [DATA_SIZE-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [15:0]              sat_count,
    input  logic                     clear_flags
);

    localparam int AW      = $clog2(DEPTH);
    localparam int RW      = FULL_SIZE + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [RW-1:0] RND      = (SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
    localparam logic [RW-1:0] SAT_MAX  = {{(RW - DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic [RW-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [RW-1:0]        rounded;
    logic signed [RW-1:0] shifted;
    logic                 clip_hi;
    logic                 clip_lo;
    logic [DATA_SIZE-1:0] scaled;

    logic                 s_valid;
    logic                 sat_pulse;
    logic [DATA_SIZE-1:0] s_data;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    // One extra bit of headroom so the rounding constant can never wrap.
    always_comb begin
        rounded = {output_data[FULL_SIZE-1], output_data} + RND;
        shifted = $signed(rounded) >>> SHIFT;
        clip_hi = shifted > $signed(SAT_MAX);
        clip_lo = shifted < $signed(SAT_MIN);
        if (clip_hi) begin
            scaled = SAT_MAX[DATA_SIZE-1:0];
        end else if (clip_lo) begin
            scaled = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            scaled = shifted[DATA_SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid   <= 1'b0;
            sat_pulse <= 1'b0;
            s_data    <= '0;
        end else begin
            s_valid   <= output_data_valid;
            sat_pulse <= output_data_valid && (clip_hi || clip_lo);
            s_data    <= scaled;
        end
    end

    assign full = (count == FULL_CNT);
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push = s_valid && (!full || pop);
    assign drop = s_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            sat_count <= '0;
        end else if (clear_flags) begin
            overflow  <= 1'b0;
            sat_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (sat_pulse && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fill_level = count;

endmodule

// File: tb/tb_convol_result_scaler_fifo.sv
// Directed and random stimulus for the scaler FIFO, checked cycle by cycle against a
// queue-based reference model; a second SHIFT=0 instance covers the no-rounding build.
module tb_convol_result_scaler_fifo;

    localparam int DS = 16;
    localparam int FS = 35;
    localparam int SH = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [FS-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          clear;
    logic [DS-1:0] out_data;
    logic          out_valid;
    logic [2:0]    fill_level;
    logic          overflow;
    logic [15:0]   sat_count;

    logic [FS-1:0] d0_data;
    logic          d0_valid;
    logic [DS-1:0] o0_data;
    logic          o0_valid;
    logic [2:0]    o0_fill;
    logic          o0_ovf;
    logic [15:0]   o0_sat;

    convol_result_scaler_fifo #(
        .DATA_SIZE(DS), .WINDOW_SIZE(8), .SHIFT(SH), .DEPTH(DP)
    ) dut (
        .clk(clk), .reset(reset),
        .output_data(in_data), .output_data_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(in_ready),
        .fill_level(fill_level), .overflow(overflow), .sat_count(sat_count),
        .clear_flags(clear)
    );

    convol_result_scaler_fifo #(
        .DATA_SIZE(DS), .WINDOW_SIZE(8), .SHIFT(0), .DEPTH(DP)
    ) dut0 (
        .clk(clk), .reset(reset),
        .output_data(d0_data), .output_data_valid(d0_valid),
        .out_data(o0_data), .out_valid(o0_valid), .out_ready(1'b1),
        .fill_level(o0_fill), .overflow(o0_ovf), .sat_count(o0_sat),
        .clear_flags(1'b0)
    );

    int       n_checks = 0;
    int       n_pass   = 0;
    longint   in_val;
    longint   q[$];
    longint   cap[$];
    bit       m_sv, m_ss, m_ovf;
    longint   m_sd;
    int       m_sat;
    longint   ins1[4] = '{64, 24, -24, 7};
    longint   exp1[4] = '{4, 2, -1, 0};

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // floor((x + half) / 2^sh) clipped to the signed 16-bit range
    function automatic longint scale(input longint x, input int sh, output bit clipped);
        longint d, v, r;
        d = 1;
        for (int i = 0; i < sh; i++) d = d * 2;
        v = x + ((sh > 0) ? d / 2 : 0);
        r = v / d;
        if ((v % d != 0) && (v < 0)) r = r - 1;
        clipped = 1'b1;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        else clipped = 1'b0;
        return r;
    endfunction

    task automatic model_edge();
        bit     c;
        longint s;
        if (reset) begin
            q.delete();
            m_sv = 0; m_ss = 0; m_ovf = 0; m_sat = 0;
            return;
        end
        if ((q.size() > 0) && in_ready) void'(q.pop_front());
        if (m_sv) begin
            if (q.size() < DP) q.push_back(m_sd);
            else m_ovf = 1;
        end
        if (m_ss && m_sat < 65535) m_sat++;
        if (clear) begin
            m_ovf = 0;
            m_sat = 0;
        end
        s = scale(in_val, SH, c);
        m_sv = in_valid;
        m_sd = s;
        m_ss = in_valid && c;
    endtask

    task automatic drive(input bit v, input longint d, input bit r);
        in_valid = v;
        in_val   = d;
        in_data  = d[FS-1:0];
        in_ready = r;
    endtask

    task automatic cycle();
        if (out_valid === 1'b1 && in_ready) cap.push_back(longint'($signed(out_data)));
        @(posedge clk);
        model_edge();
        #1;
        check("valid", 64'(out_valid), 64'(q.size() != 0));
        check("fill", 64'(fill_level), 64'(q.size()));
        if (q.size() > 0) check("head", 64'($signed(out_data)), q[0]);
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("sat_count", 64'(sat_count), 64'(m_sat));
    endtask

    function automatic longint cap_at(input int i);
        return (cap.size() > i) ? cap[i] : 64'sd999999;
    endfunction

    initial begin
        logic [FS-1:0] tmp;
        int            mode;
        longint        d;

        reset = 1; clear = 0; d0_data = '0; d0_valid = 0;
        drive(0, 0, 0);
        cycle();
        cycle();
        reset = 0;
        check("rst_data", 64'(out_data), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_fill", 64'(fill_level), 0);
        check("rst_ovf", 64'(overflow), 0);
        check("rst_sat", 64'(sat_count), 0);

        // rounding, two-cycle latency
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1, ins1[i], 1);
            else drive(0, 0, 1);
            cycle();
            if (i >= 1 && i <= 4) begin
                check("t1_valid", 64'(out_valid), 1);
                check("t1_data", 64'($signed(out_data)), exp1[i-1]);
            end
        end
        check("t1_sat", 64'(sat_count), 0);

        // saturation both ways, then clear
        cap.delete();
        drive(1, longint'(1) << 30, 1); cycle();
        drive(1, -(longint'(1) << 30), 1); cycle();
        drive(0, 0, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("t2_count", 64'(cap.size()), 2);
        check("t2_pos", cap_at(0), 32767);
        check("t2_neg", cap_at(1), -32768);
        check("t2_sat", 64'(sat_count), 2);
        clear = 1; cycle(); clear = 0;
        check("t2_clear", 64'(sat_count), 0);

        // backpressure and overflow
        for (int k = 1; k <= 6; k++) begin
            drive(1, 16 * k, 0);
            cycle();
        end
        drive(0, 0, 0); cycle(); cycle();
        check("t3_fill", 64'(fill_level), 4);
        check("t3_ovf", 64'(overflow), 1);
        cap.delete();
        drive(0, 0, 1);
        for (int i = 0; i < 6; i++) cycle();
        check("t3_count", 64'(cap.size()), 4);
        for (int i = 0; i < 4; i++) check("t3_data", cap_at(i), i + 1);
        check("t3_drained", 64'(fill_level), 0);
        clear = 1; cycle(); clear = 0;

        // full FIFO with push and pop every cycle
        for (int k = 1; k <= 4; k++) begin
            drive(1, 16 * k, 0);
            cycle();
        end
        drive(0, 0, 0); cycle();
        cap.delete();
        drive(1, 16 * 5, 0); cycle();
        check("t4_prefill", 64'(fill_level), 4);
        for (int k = 6; k <= 15; k++) begin
            drive(1, 16 * k, 1);
            cycle();
            check("t4_fill", 64'(fill_level), 4);
            check("t4_ovf", 64'(overflow), 0);
        end
        drive(0, 0, 1);
        for (int i = 0; i < 7; i++) cycle();
        check("t4_count", 64'(cap.size()), 15);
        for (int i = 0; i < 15; i++) check("t4_order", cap_at(i), i + 1);

        // reset with three stored and one in flight
        for (int k = 1; k <= 4; k++) begin
            drive(1, 16 * k, 0);
            cycle();
        end
        reset = 1; drive(0, 0, 0); cycle(); reset = 0;
        check("t5_valid", 64'(out_valid), 0);
        check("t5_fill", 64'(fill_level), 0);
        cap.delete();
        drive(1, 32, 1); cycle();
        drive(0, 0, 1);
        for (int i = 0; i < 4; i++) cycle();
        check("t5_count", 64'(cap.size()), 1);
        check("t5_data", cap_at(0), 2);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: d = longint'($urandom_range(0, 4000)) - 2000;
                1: d = 32767 * 16 - 16 + longint'($urandom_range(0, 40));
                2: d = -32768 * 16 - 24 + longint'($urandom_range(0, 40));
                default: begin
                    tmp = FS'({$urandom(), $urandom()});
                    d = longint'($signed(tmp));
                end
            endcase
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clear = 0;
        drive(0, 0, 1);
        for (int i = 0; i < 8; i++) cycle();
        check("rand_empty", 64'(fill_level), 0);

        // SHIFT=0 instance: no rounding, saturation only
        d0_valid = 1; d0_data = FS'(1234); cycle();
        d0_data = FS'(40000); cycle();
        check("s0_valid", 64'(o0_valid), 1);
        check("s0_pass", 64'($signed(o0_data)), 1234);
        d0_valid = 0; cycle();
        check("s0_sat_data", 64'($signed(o0_data)), 32767);
        check("s0_sat_count", 64'(o0_sat), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
